stream_arb_2to1: RTL and testbench
==================================

// Module: stream_arb_2to1
// PURPOSE
//   Upstream control stage for mux_2to1. Arbitrates two valid/ready input
//   streams (A, B) round-robin, steers the winner through a per-bit bank of
//   mux_2to1, and registers the result in a one-entry output buffer.
//   Drives the downstream consumer; exports the registered select as sel.
// PARAMETERS
//   DATA_W   8   width of a_data / b_data / out_data
// PORTS
//   clk        in   1        single clock; all state updates on posedge
//   rst        in   1        asynchronous, active-high reset
//   a_valid    in   1        stream A has data
//   a_data     in   DATA_W   stream A payload
//   a_ready    out  1        stream A transfer accepted this cycle
//   b_valid    in   1        stream B has data
//   b_data     in   DATA_W   stream B payload
//   b_ready    out  1        stream B transfer accepted this cycle
//   out_valid  out  1        output buffer holds data
//   out_data   out  DATA_W   buffered payload
//   out_ready  in   1        consumer accepts out_data
//   sel        out  1        source of out_data: 0=A, 1=B (mux_2to1 coding)
// BEHAVIOUR
//   - Reset: out_valid=0, out_data=0, sel=0, last_grant=B (A wins first tie).
//     a_ready/b_ready are 0 while rst is high.
//   - Buffer states: EMPTY (out_valid=0), FULL (out_valid=1).
//     load_en = !out_valid | out_ready  (drain and refill same cycle allowed).
//   - Grant (comb): only A valid -> A; only B valid -> B; both -> opposite of
//     last_grant; neither -> none. a_ready = load_en & grant==A; b_ready
//     likewise; at most one ready high per cycle.
//   - Transfer: on posedge with load_en and a grant: out_data <= muxed data,
//     sel <= grant, last_grant <= grant, out_valid <= 1.
//     load_en with no grant: out_valid <= 0 (EMPTY).
//   - FULL and !out_ready: out_data, sel, out_valid hold; both readies 0.
//   - Latency: 1 cycle input accept -> out_valid; full throughput 1 word/cycle.
//   - Fairness: with both valid continuously and out_ready=1, grants strictly
//     alternate A,B,A,B...
//   - last_grant updates only on an actual transfer, never on idle cycles.
//   - Input valid dropping without ready is legal; no state change results.
//   - rst asserted mid-operation: buffered word discarded, state to reset
//     values immediately (async), no transfer on the clock edge under rst.
//   - ready depends combinationally on out_ready; valid never depends on ready.
// STRUCTURE
//   - Shared header arb_defs.vh: localparams SRC_A=1'b0, SRC_B=1'b1.
//   - Sub-module: mux_2to1, generate-instantiated DATA_W times, sel tied to
//     the combinational grant (a -> bit of a_data, b -> bit of b_data).
//   - Registers: out_valid, out_data, sel, last_grant; no other state.
// TESTING
//   1 Reset: rst=1 with a_valid=b_valid=1 -> out_valid=0, out_data=0, sel=0,
//     a_ready=b_ready=0; release rst -> first accept is A.
//   2 Single source: a_valid=1,a_data=8'h3C,b_valid=0,out_ready=1 -> a_ready=1;
//     next cycle out_valid=1, out_data=8'h3C, sel=0.
//   3 Tie alternation: both valid, a_data=8'hAA, b_data=8'h55, out_ready=1 for
//     4 cycles -> out_data AA,55,AA,55; sel 0,1,0,1.
//   4 Backpressure: buffer FULL with 8'h11, out_ready=0 for 3 cycles -> out_data
//     stays 8'h11, a_ready=b_ready=0; out_ready=1 -> refill same cycle.
//   5 Drain to empty: FULL, out_ready=1, no valids -> out_valid=0 next cycle,
//     last_grant unchanged (verify by next tie grant).
//   6 Async reset mid-stream: assert rst between edges while FULL -> out_valid
//     drops before next posedge; resume gives A priority on tie.

Source files
------------

// File: rtl/stream_arb_2to1_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_2to1_pkg
//   Shared definitions for the two-input round-robin stream arbiter:
//   source coding (matches the mux_2to1 select coding), output buffer
//   state type and the round-robin tie-break helper.
// -----------------------------------------------------------------------------
package stream_arb_2to1_pkg;

    // Source coding: also the select value driven into mux_2to1.
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // One-entry output buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Pick a source from the two valids; on a tie, favour the source that
    // did not win the previous transfer. Result is meaningless when neither
    // input is valid (the caller qualifies it with a separate grant-valid).
    function automatic logic pick_src(input logic a_valid,
                                      input logic b_valid,
                                      input logic last_grant);
        logic src;
        if (a_valid && b_valid) begin
            src = ~last_grant;
        end else if (a_valid) begin
            src = SRC_A;
        end else begin
            src = SRC_B;
        end
        return src;
    endfunction

endpackage : stream_arb_2to1_pkg

// File: rtl/stream_arb_2to1_mux_2to1.sv
// -----------------------------------------------------------------------------
// mux_2to1
//   Single-bit two-input multiplexer.
// Ports:
//   a_i    in   1   input selected when sel_i = 0
//   b_i    in   1   input selected when sel_i = 1
//   sel_i  in   1   select
//   y_o    out  1   selected bit
// -----------------------------------------------------------------------------
module mux_2to1 (
    input  logic a_i,
    input  logic b_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule : mux_2to1

// File: rtl/stream_arb_2to1.sv
// -----------------------------------------------------------------------------
// stream_arb_2to1
//   Arbitrates two valid/ready streams (A, B) round-robin, steers the winner
//   through a per-bit bank of mux_2to1 and registers it in a one-entry output
//   buffer. Exports the source of the buffered word as sel_o.
// Parameters:
//   DATA_W       payload width
// Ports:
//   clk_i        in   1       clock, all state updates on posedge
//   rst_i        in   1       asynchronous active-high reset
//   a_valid_i    in   1       stream A has data
//   a_data_i     in   DATA_W  stream A payload
//   a_ready_o    out  1       stream A word accepted this cycle
//   b_valid_i    in   1       stream B has data
//   b_data_i     in   DATA_W  stream B payload
//   b_ready_o    out  1       stream B word accepted this cycle
//   out_valid_o  out  1       output buffer holds data
//   out_data_o   out  DATA_W  buffered payload
//   out_ready_i  in   1       consumer accepts out_data_o
//   sel_o        out  1       source of out_data_o: 0 = A, 1 = B
// -----------------------------------------------------------------------------
module stream_arb_2to1
    import stream_arb_2to1_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic              sel_o
);

    buf_state_t        state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              sel_q, sel_d;
    logic              last_grant_q, last_grant_d;

    logic              load_en;
    logic              grant_valid;
    logic              grant_src;
    logic [DATA_W-1:0] muxed_data;

    // Buffer may load when empty, or when the consumer drains it this cycle.
    assign load_en     = (state_q == BUF_EMPTY) || out_ready_i;
    assign grant_valid = a_valid_i || b_valid_i;
    assign grant_src   = pick_src(a_valid_i, b_valid_i, last_grant_q);

    // Readies are forced low while reset is held so nothing is handed
    // over on an edge that the registers will ignore.
    assign a_ready_o = !rst_i && load_en && grant_valid && (grant_src == SRC_A);
    assign b_ready_o = !rst_i && load_en && grant_valid && (grant_src == SRC_B);

    // Per-bit steering of the winning payload.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mux
            mux_2to1 u_mux (
                .a_i   (a_data_i[gi]),
                .b_i   (b_data_i[gi]),
                .sel_i (grant_src),
                .y_o   (muxed_data[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            if (grant_valid) begin
                state_d      = BUF_FULL;
                out_data_d   = muxed_data;
                sel_d        = grant_src;
                last_grant_d = grant_src;
            end else begin
                // Drained with nothing to refill: data/sel keep their
                // last value, only occupancy changes.
                state_d = BUF_EMPTY;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= BUF_EMPTY;
            out_data_q   <= '0;
            sel_q        <= SRC_A;
            last_grant_q <= SRC_B;  // so A wins the first tie
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid_o = (state_q == BUF_FULL);
    assign out_data_o  = out_data_q;
    assign sel_o       = sel_q;

endmodule : stream_arb_2to1

// File: tb/tb_stream_arb_2to1.sv
module tb_stream_arb_2to1;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst;
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              sel;

    int errors = 0;
    int checks = 0;

    stream_arb_2to1 #(.DATA_W(DATA_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .a_valid_i   (a_valid),
        .a_data_i    (a_data),
        .a_ready_o   (a_ready),
        .b_valid_i   (b_valid),
        .b_data_i    (b_data),
        .b_ready_o   (b_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .sel_o       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge; inputs are driven
    // and outputs sampled there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        a_data = 8'h12; b_data = 8'h34; out_ready = 1'b1;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel got=%b exp=0", sel); end
        checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL reset_readies got=%b exp=00", {a_ready, b_ready}); end
        rst = 1'b0;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL reset_first_tie_ready got=%b exp=10", {a_ready, b_ready}); end
        step();
        checks++; if ({out_valid, out_data, sel} !== {1'b1, 8'h12, 1'b0}) begin errors++; $display("FAIL reset_first_accept got=%b/%h/%b exp=1/12/0", out_valid, out_data, sel); end
        $display("test_reset: out_valid=%b out_data=%h sel=%b", out_valid, out_data, sel);
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_data = 8'h3C; b_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got=%b exp=10", {a_ready, b_ready}); end
        step();
        checks++; if ({out_valid, out_data, sel} !== {1'b1, 8'h3C, 1'b0}) begin errors++; $display("FAIL single_out got=%b/%h/%b exp=1/3c/0", out_valid, out_data, sel); end
        $display("test_single: out_data=%h sel=%b", out_data, sel);
        a_valid = 1'b0;
        step();
    endtask

    task automatic test_tie_alternation();
        logic [DATA_W-1:0] exp_data [4];
        logic              exp_sel  [4];
        exp_data[0] = 8'hAA; exp_data[1] = 8'h55; exp_data[2] = 8'hAA; exp_data[3] = 8'h55;
        exp_sel[0]  = 1'b0;  exp_sel[1]  = 1'b1;  exp_sel[2]  = 1'b0;  exp_sel[3]  = 1'b1;
        pulse_reset();
        a_valid = 1'b1; a_data = 8'hAA; b_valid = 1'b1; b_data = 8'h55; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({a_ready, b_ready} !== {~exp_sel[i], exp_sel[i]}) begin errors++; $display("FAIL tie_ready[%0d] got=%b exp=%b", i, {a_ready, b_ready}, {~exp_sel[i], exp_sel[i]}); end
            step();
            checks++; if ({out_valid, out_data, sel} !== {1'b1, exp_data[i], exp_sel[i]}) begin errors++; $display("FAIL tie_out[%0d] got=%b/%h/%b exp=1/%h/%b", i, out_valid, out_data, sel, exp_data[i], exp_sel[i]); end
            $display("test_tie[%0d]: out_data=%h sel=%b", i, out_data, sel);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b0; out_ready = 1'b1;
        step();
        // last transfer was A; now stall with both valid
        out_ready = 1'b0;
        a_data = 8'h22; b_valid = 1'b1; b_data = 8'h33;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, {a_ready, b_ready}); end
            step();
            checks++; if ({out_valid, out_data, sel} !== {1'b1, 8'h11, 1'b0}) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/11/0", i, out_valid, out_data, sel); end
            $display("test_backpressure[%0d]: out_data=%h", i, out_data);
        end
        out_ready = 1'b1;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL bp_refill_ready got=%b exp=01", {a_ready, b_ready}); end
        step();
        checks++; if ({out_valid, out_data, sel} !== {1'b1, 8'h33, 1'b1}) begin errors++; $display("FAIL bp_refill got=%b/%h/%b exp=1/33/1", out_valid, out_data, sel); end
        $display("test_backpressure refill: out_data=%h sel=%b", out_data, sel);
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_drain();
        a_valid = 1'b1; a_data = 8'h44; b_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if ({out_valid, out_data, sel} !== {1'b1, 8'h44, 1'b0}) begin errors++; $display("FAIL drain_fill got=%b/%h/%b exp=1/44/0", out_valid, out_data, sel); end
        a_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
        step();
        step();
        // last grant must still be A after idle cycles, so the tie goes to B
        a_valid = 1'b1; a_data = 8'h5A; b_valid = 1'b1; b_data = 8'hA5;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL drain_tie_ready got=%b exp=01", {a_ready, b_ready}); end
        step();
        checks++; if ({out_valid, out_data, sel} !== {1'b1, 8'hA5, 1'b1}) begin errors++; $display("FAIL drain_tie_out got=%b/%h/%b exp=1/a5/1", out_valid, out_data, sel); end
        $display("test_drain: out_data=%h sel=%b", out_data, sel);
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL async_pre_full got=%b exp=1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({out_valid, out_data, sel} !== {1'b0, 8'h00, 1'b0}) begin errors++; $display("FAIL async_clear got=%b/%h/%b exp=0/00/0", out_valid, out_data, sel); end
        #1 rst = 1'b0;
        a_valid = 1'b1; a_data = 8'h77; b_valid = 1'b1; b_data = 8'h88; out_ready = 1'b1;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL async_resume_ready got=%b exp=10", {a_ready, b_ready}); end
        step();
        checks++; if ({out_valid, out_data, sel} !== {1'b1, 8'h77, 1'b0}) begin errors++; $display("FAIL async_resume_out got=%b/%h/%b exp=1/77/0", out_valid, out_data, sel); end
        $display("test_async_reset: out_data=%h sel=%b", out_data, sel);
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie_alternation();
        test_backpressure();
        test_drain();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_stream_arb_2to1
